atomic_seq_ctrl: RTL

//  Sequences one atomic-clock measurement cycle as phases LOAD -> COOL -> PROBE -> DETECT.

---
 rtl/atomic_seq_if.sv | 39 +++
 rtl/atomic_seq_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/atomic_seq_if.sv
// Run-control / phase-output bundle for atomic_seq_ctrl.
// Optional SEQ_CONTINUOUS_EN adds the 'run' input.
interface atomic_seq_if #(
  parameter int unsigned Nbits = 27
);
  logic             start;
  logic             abort;
  logic             hold;
`ifdef SEQ_CONTINUOUS_EN
  logic             run;
`endif
  logic             busy;
  logic [2:0]       phase;
  logic             load_en;
  logic             cool_en;
  logic             probe_en;
  logic             detect_en;
  logic [Nbits-1:0] phase_cnt;
  logic             done;
  logic             aborted;

  // Top-level run control side
  modport master (
    output start, abort, hold,
`ifdef SEQ_CONTINUOUS_EN
    run,
`endif
    input  busy, phase, load_en, cool_en, probe_en, detect_en, phase_cnt, done, aborted
  );

  // Sequencer side
  modport slave (
    input  start, abort, hold,
`ifdef SEQ_CONTINUOUS_EN
    run,
`endif
    output busy, phase, load_en, cool_en, probe_en, detect_en, phase_cnt, done, aborted
  );
endinterface

// File: rtl/atomic_seq_ctrl.sv
// Atomic-clock measurement sequencer: IDLE -> LOAD -> COOL -> PROBE -> DETECT -> DONE.
// Each timed phase lasts exactly T_* clk cycles, counted by phase_cnt.
// Define SEQ_CONTINUOUS_EN to restart from DONE into LOAD while 'run' is high.
module atomic_seq_ctrl #(
  parameter int unsigned Nbits    = 27,
  parameter int unsigned T_LOAD   = 48415000,
  parameter int unsigned T_COOL   = 9683000,
  parameter int unsigned T_PROBE  = 968300,
  parameter int unsigned T_DETECT = 4841500
) (
  input  logic        clk,
  input  logic        reset,
  atomic_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    COOL   = 3'd2,
    PROBE  = 3'd3,
    DETECT = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Phase lengths must fit the counter and be non-zero
  if ((T_LOAD == 0) || (64'(T_LOAD) >= (64'd1 << Nbits))) begin : g_bad_load
    $error("atomic_seq_ctrl: T_LOAD out of range");
  end
  if ((T_COOL == 0) || (64'(T_COOL) >= (64'd1 << Nbits))) begin : g_bad_cool
    $error("atomic_seq_ctrl: T_COOL out of range");
  end
  if ((T_PROBE == 0) || (64'(T_PROBE) >= (64'd1 << Nbits))) begin : g_bad_probe
    $error("atomic_seq_ctrl: T_PROBE out of range");
  end
  if ((T_DETECT == 0) || (64'(T_DETECT) >= (64'd1 << Nbits))) begin : g_bad_detect
    $error("atomic_seq_ctrl: T_DETECT out of range");
  end

  localparam logic [Nbits-1:0] TC_LOAD   = Nbits'(T_LOAD - 1);
  localparam logic [Nbits-1:0] TC_COOL   = Nbits'(T_COOL - 1);
  localparam logic [Nbits-1:0] TC_PROBE  = Nbits'(T_PROBE - 1);
  localparam logic [Nbits-1:0] TC_DETECT = Nbits'(T_DETECT - 1);
  localparam logic [Nbits-1:0] CNT_ONE   = Nbits'(1);

  state_t           state, state_n;
  logic [Nbits-1:0] cnt, cnt_n;
  logic             aborted_q, aborted_n;
  logic [Nbits-1:0] tc;
  state_t           succ;

  // Terminal count and successor for the current timed phase
  always_comb begin
    tc   = '0;
    succ = IDLE;
    case (state)
      LOAD:    begin tc = TC_LOAD;   succ = COOL;   end
      COOL:    begin tc = TC_COOL;   succ = PROBE;  end
      PROBE:   begin tc = TC_PROBE;  succ = DETECT; end
      DETECT:  begin tc = TC_DETECT; succ = DONE;   end
      default: begin tc = '0;        succ = IDLE;   end
    endcase
  end

  // Next-state, counter and abort-pulse logic; abort outranks hold, phase end and start
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    aborted_n = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_n = LOAD;
          cnt_n   = '0;
        end
      end
      LOAD, COOL, PROBE, DETECT: begin
        if (bus.abort) begin
          state_n   = IDLE;
          cnt_n     = '0;
          aborted_n = 1'b1;
        end else if (!bus.hold) begin
          if (cnt == tc) begin
            state_n = succ;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
      end
      DONE: begin
        cnt_n = '0;
        if (bus.abort) begin
          state_n   = IDLE;
          aborted_n = 1'b1;
        end else begin
`ifdef SEQ_CONTINUOUS_EN
          state_n = bus.run ? LOAD : IDLE;
`else
          state_n = IDLE;
`endif
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter and abort-pulse registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      aborted_q <= aborted_n;
    end
  end

  assign bus.phase     = state;
  assign bus.busy      = (state != IDLE);
  assign bus.load_en   = (state == LOAD);
  assign bus.cool_en   = (state == COOL);
  assign bus.probe_en  = (state == PROBE);
  assign bus.detect_en = (state == DETECT);
  assign bus.done      = (state == DONE);
  assign bus.phase_cnt = cnt;
  assign bus.aborted   = aborted_q;

endmodule
